// File: rtl/pattern_source_pkg.sv
// Shared types for the pattern source: pattern modes, FSM states and default LFSR taps.
package pattern_source_pkg;

  typedef enum logic [1:0] {
    PAT_CONST = 2'd0,
    PAT_COUNT = 2'd1,
    PAT_WALK  = 2'd2,
    PAT_LFSR  = 2'd3
  } pat_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pat_state_e;

  // Galois feedback mask for an 8-bit maximal-length sequence.
  localparam logic [7:0] LFSR_TAPS_W8 = 8'hB8;

endpackage

// File: rtl/pattern_next.sv
// Combinational word generator: initial word (init=1) or successor of word (init=0).
// Zero latency, no handshake; LFSR branch present only with PATTERN_SOURCE_LFSR_EN.
module pattern_next
  import pattern_source_pkg::*;
#(
  parameter int                WIDTH = 8,
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(LFSR_TAPS_W8)
) (
  input  pat_mode_e          mode,
  input  logic               init,
  input  logic [WIDTH-1:0]   seed,
  input  logic [WIDTH-1:0]   word,
  output logic [WIDTH-1:0]   next_word
);

`ifndef PATTERN_SOURCE_LFSR_EN
  // Taps only matter when the LFSR is built; keep the parameter referenced.
  logic unused_taps;
  assign unused_taps = ^TAPS;
`endif

  always_comb begin
    next_word = word;
    if (init) begin
      case (mode)
        PAT_CONST: next_word = seed;
        PAT_COUNT: next_word = seed;
        PAT_WALK:  next_word = WIDTH'(1);
`ifdef PATTERN_SOURCE_LFSR_EN
        // An all-zero LFSR state would lock up, so substitute 1.
        PAT_LFSR:  next_word = (seed == '0) ? WIDTH'(1) : seed;
`else
        PAT_LFSR:  next_word = '0;
`endif
        default:   next_word = seed;
      endcase
    end else begin
      case (mode)
        PAT_CONST: next_word = word;
        PAT_COUNT: next_word = word + WIDTH'(1);
        PAT_WALK:  next_word = {word[WIDTH-2:0], word[WIDTH-1]};
`ifdef PATTERN_SOURCE_LFSR_EN
        PAT_LFSR:  next_word = (word >> 1) ^ (word[0] ? TAPS : '0);
`else
        PAT_LFSR:  next_word = '0;
`endif
        default:   next_word = word;
      endcase
    end
  end

endmodule

// File: rtl/pattern_source.sv
// Burst data source (const/count/walk/LFSR) on valid/ready; first valid 1 cycle after start.
// Data/last hold while stalled. LFSR mode needs PATTERN_SOURCE_LFSR_EN, else mode 3 emits zeros.
module pattern_source
  import pattern_source_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               LEN_W     = 8,
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(LFSR_TAPS_W8)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   seed,
  input  logic [LEN_W-1:0]   burst_len,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  pat_state_e          state_q, state_d;
  pat_mode_e           mode_q;
  pat_mode_e           mode_sel;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [WIDTH-1:0]    data_q;
  logic [WIDTH-1:0]    nxt_word;
  logic                gen_init;
  logic                load;
  logic                adv;
  logic                last_beat;

  // In IDLE the generator produces the first word from the live inputs;
  // otherwise it advances the held word using the latched mode.
  assign gen_init = (state_q == ST_IDLE);
  assign mode_sel = gen_init ? pat_mode_e'(mode) : mode_q;

  pattern_next #(
    .WIDTH (WIDTH),
    .TAPS  (LFSR_TAPS)
  ) u_next (
    .mode      (mode_sel),
    .init      (gen_init),
    .seed      (seed),
    .word      (data_q),
    .next_word (nxt_word)
  );

  assign last_beat = (cnt_q == (len_q - LEN_W'(1)));

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    adv       = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            load    = 1'b1;
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        out_valid = 1'b1;
        out_last  = last_beat;
        busy      = 1'b1;
        if (out_ready) begin
          adv = 1'b1;
          if (last_beat) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= PAT_CONST;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        mode_q <= pat_mode_e'(mode);
        len_q  <= burst_len;
        cnt_q  <= '0;
        data_q <= nxt_word;
      end else if (adv) begin
        cnt_q  <= cnt_q + LEN_W'(1);
        data_q <= nxt_word;
      end
    end
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_pattern_source.sv
// Directed table-driven bench for pattern_source plus stall, zero-length and reset sequences.
module tb_pattern_source;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  logic [7:0] seed;
  logic [7:0] burst_len;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       done;

  int n_vec  = 0;
  int n_fail = 0;

  pattern_source #(
    .WIDTH     (8),
    .LEN_W     (8),
    .LFSR_TAPS (8'hB8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .seed      (seed),
    .burst_len (burst_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]      mode;
    logic [7:0]      seed;
    logic [7:0]      len;
    logic [8:0][7:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input vec_t v, input int idx);
    start     = 1'b1;
    mode      = v.mode;
    seed      = v.seed;
    burst_len = v.len;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    mode      = 2'($urandom_range(3, 0));
    seed      = 8'($urandom);
    burst_len = 8'($urandom);
    for (int i = 0; i < int'(v.len); i++) begin
      chk($sformatf("v%0d beat%0d valid", idx, i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d beat%0d data", idx, i), 32'(out_data), 32'(v.exp[i]));
      chk($sformatf("v%0d beat%0d last", idx, i), 32'(out_last), (i == int'(v.len) - 1) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d beat%0d busy", idx, i), 32'(busy), 32'd1);
      tick();
    end
    chk($sformatf("v%0d done pulse", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d valid after last", idx), 32'(out_valid), 32'd0);
    tick();
    chk($sformatf("v%0d done cleared", idx), 32'(done), 32'd0);
    chk($sformatf("v%0d idle busy", idx), 32'(busy), 32'd0);
  endtask

  logic [4:0] rdy_pat;
  logic [4:0] last_pat;
  int         hs;

  initial begin
    tbl[0] = '{mode: 2'd1, seed: 8'hFE, len: 8'd4,
               exp: {40'h0, 8'h01, 8'h00, 8'hFF, 8'hFE}};
    tbl[1] = '{mode: 2'd2, seed: 8'h00, len: 8'd9,
               exp: {8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01}};
`ifdef PATTERN_SOURCE_LFSR_EN
    tbl[2] = '{mode: 2'd3, seed: 8'h00, len: 8'd4,
               exp: {40'h0, 8'h2E, 8'h5C, 8'hB8, 8'h01}};
    tbl[3] = '{mode: 2'd3, seed: 8'h03, len: 8'd3,
               exp: {48'h0, 8'hE4, 8'hB9, 8'h03}};
`else
    tbl[2] = '{mode: 2'd3, seed: 8'h00, len: 8'd4, exp: '0};
    tbl[3] = '{mode: 2'd3, seed: 8'h03, len: 8'd3, exp: '0};
`endif
    tbl[4] = '{mode: 2'd0, seed: 8'hA5, len: 8'd2,
               exp: {56'h0, 8'hA5, 8'hA5}};
    tbl[5] = '{mode: 2'd1, seed: 8'h10, len: 8'd1,
               exp: {64'h0, 8'h10}};
    tbl[6] = '{mode: 2'd2, seed: 8'hFF, len: 8'd2,
               exp: {56'h0, 8'h02, 8'h01}};
    tbl[7] = '{mode: 2'd1, seed: 8'h07, len: 8'd2,
               exp: {56'h0, 8'h08, 8'h07}};

    reset     = 1'b1;
    start     = 1'b0;
    mode      = 2'd0;
    seed      = 8'h00;
    burst_len = 8'd0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("reset valid", 32'(out_valid), 32'd0);
    chk("reset data", 32'(out_data), 32'd0);
    chk("reset last", 32'(out_last), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 7; v++) begin
      run_burst(tbl[v], v);
    end

    // CONST burst of 3 with stalls: handshakes on cycles 0, 3 and 4.
    rdy_pat   = 5'b11001;
    last_pat  = 5'b10000;
    hs        = 0;
    start     = 1'b1;
    mode      = 2'd0;
    seed      = 8'h00;
    burst_len = 8'd3;
    out_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      out_ready = rdy_pat[i];
      chk($sformatf("stall c%0d valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("stall c%0d data", i), 32'(out_data), 32'h00);
      chk($sformatf("stall c%0d last", i), 32'(out_last), 32'(last_pat[i]));
      if (out_valid && out_ready) hs++;
      tick();
    end
    out_ready = 1'b0;
    chk("stall handshakes", 32'(hs), 32'd3);
    chk("stall done", 32'(done), 32'd1);
    chk("stall valid end", 32'(out_valid), 32'd0);
    tick();

    // Zero-length burst, with a second start held during the DONE cycle.
    start     = 1'b1;
    mode      = 2'd1;
    burst_len = 8'd0;
    out_ready = 1'b1;
    tick();
    chk("len0 valid", 32'(out_valid), 32'd0);
    chk("len0 done", 32'(done), 32'd1);
    chk("len0 busy", 32'(busy), 32'd1);
    burst_len = 8'd4;
    tick();
    start = 1'b0;
    chk("len0 restart ignored valid", 32'(out_valid), 32'd0);
    chk("len0 restart ignored busy", 32'(busy), 32'd0);
    chk("len0 done cleared", 32'(done), 32'd0);
    tick();
    chk("len0 still idle", 32'(busy), 32'd0);

    // Reset after 2 of 5 beats abandons the burst with no done pulse.
    start     = 1'b1;
    mode      = 2'd1;
    seed      = 8'h00;
    burst_len = 8'd5;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("abort pre data", 32'(out_data), 32'h02);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort valid", 32'(out_valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort no done c%0d", i), 32'(done), 32'd0);
      tick();
    end
    run_burst(tbl[7], 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_source.md
# pattern_source

Parametrised, handshaked data source; successor to the fixed constant-zero driver. On `start`, it emits a burst of `burst_len` words over a valid/ready interface. Words follow one of four patterns: constant (zero by default), up-count, walking-one or LFSR. Used as a stimulus/filler source in front of any ready/valid consumer in the design.

## Interface
- `WIDTH`, 8: data word width (≥2).
- `LEN_W`, 8: width of the burst-length field.
- `LFSR_TAPS`, 8'hB8: Galois feedback mask, `WIDTH` bits.
- `clk`  in  1: sole clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a burst; sampled only in IDLE.
- `mode`  in  2: pattern select, latched on accepted `start`. Encoding: 0 CONST, 1 COUNT, 2 WALK, 3 LFSR.
- `seed`  in  WIDTH: constant value / count start / LFSR seed, latched on `start`.
- `burst_len`  in  LEN_W: number of beats, latched on `start`.
- `out_valid`  out  1: word available.
- `out_ready`  in  1: consumer accepts the word.
- `out_data`  out  WIDTH: current word.
- `out_last`  out  1: final beat of the burst, qualified by `out_valid`.
- `busy`  out  1: high in RUN and DONE.
- `done`  out  1: one-cycle pulse after the burst completes.

## Operation
- FSM states are IDLE, RUN and DONE. Reset forces IDLE.
  - Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0, beat counter 0.
- IDLE, `start`=1, `burst_len`≠0:
  - latch `mode`, `seed` and `burst_len`;
  - load the initial word;
  - go to RUN.
- IDLE, `start`=1, `burst_len`=0: go to DONE directly. No beat is emitted.
- RUN:
  - `out_valid`=1.
  - A handshake occurs when `out_valid & out_ready` at a rising edge. Each handshake advances the word and increments the beat counter.
  - `out_last`=1 when beats_sent == len−1.
  - The handshake on the last beat moves the FSM to DONE.
- DONE: `done`=1 for exactly one cycle, then return to IDLE.
- Initial word and advance rule per mode:
  - CONST: initial word is `seed`; the word never changes.
  - COUNT: initial word is `seed`; next = word+1 mod 2^WIDTH, so FF wraps to 00.
  - WALK: initial word is 1 (bit 0); next = rotate-left by 1, so bit WIDTH−1 wraps to bit 0. `seed` is ignored.
  - LFSR: initial word is `seed`, or 1 if `seed`==0. Next = (w>>1) ^ (w[0] ? `LFSR_TAPS` : 0).
- `start` while `busy` is ignored. Inputs other than `out_ready` are don't-care outside IDLE.
- Reset has priority over every other event, including mid-burst: the burst is abandoned and no `done` pulse is generated.

## Timing
- Start-to-first-valid latency is 1 cycle: `start` sampled at edge N, so `out_valid`=1 after edge N.
- Throughput is one beat per cycle while `out_ready` is held high.
- Backpressure: while `out_valid & !out_ready`, `out_data` and `out_last` stay stable.
- `out_valid` never drops in RUN until the last handshake.
- `out_valid` falls on the same edge that moves the FSM to DONE; `done` is high in the following cycle.
- Earliest next accepted `start` is the cycle after `done`, i.e. when back in IDLE.
- `burst_len`=0: `done` pulses in the cycle after `start`; `busy` is high for that one cycle.

## Configuration
- With `PATTERN_SOURCE_LFSR_EN` defined: LFSR mode is implemented as above.
- Without it: mode 3 aliases to CONST with a word of all-zero, and `seed` is ignored. No LFSR logic is synthesised.

## Structure
- A shared package `pattern_source_pkg` holds:
  - the mode enum (`PAT_CONST`, `PAT_COUNT`, `PAT_WALK`, `PAT_LFSR`);
  - the FSM state enum;
  - the default tap constant `LFSR_TAPS_W8`.
- One sub-module, `pattern_next`: combinational next-word function of (mode, word). It is reused for both initial-word selection and advance.
- The top level holds the FSM, beat counter and output registers.

## Test plan
- COUNT, seed=8'hFE, len=4, `out_ready` held 1 → data FE, FF, 00, 01 on consecutive cycles; `out_last` on 01; `done` one cycle later.
- WALK, len=9 → 01, 02, 04, 08, 10, 20, 40, 80, 01; `out_last` on the 9th beat.
- LFSR, seed=0, len=4 → 01, B8, 5C, 2E. With the macro undefined → 00 ×4.
- CONST, seed=0, len=3, `out_ready` toggled 1,0,0,1,1 → words stay at 00; exactly 3 handshakes; data/last stable while stalled.
- len=0 `start` → no `out_valid`; `done` pulse 1 cycle later. A second `start` during that cycle is ignored.
- `reset` asserted after 2 of 5 beats → next cycle `out_valid`=0, `busy`=0, `done` never pulses. A new `start` works normally afterwards.
